// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for a 5-stage pipeline: boot hold, RAW/load-use stalls, branch/jump
// redirect and halt/resume. Define FWD_EN to add EX operand forwarding (only load-use stalls).
module pipeline_hazard_ctrl #(
   parameter int BOOT_CYCLES = 2,
   parameter int REG_W       = 5,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_reg_write,
   input  logic             halt_req,
   input  logic             resume,
   output logic             le_pc,
   output logic             le_npc,
   output logic             le_if_id,
   output logic             flush_if_id,
   output logic             nop_id_ex,
   output logic [1:0]       pc_sel,
   output logic             halted,
`ifdef FWD_EN
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
`endif
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [7:0]       BOOT_LAST = 8'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [7:0]       boot_cnt_q, boot_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic match_ex_rd, match_mem_rd, hazard;

   // Register 0 is hard-wired zero, so a dependency on it is never a hazard.
   assign match_ex_rd  = (ex_rd != '0) &&
                         ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
   assign match_mem_rd = (mem_rd != '0) &&
                         ((id_uses_rs && (mem_rd == id_rs)) || (id_uses_rt && (mem_rd == id_rt)));

`ifdef FWD_EN
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
      if (src != '0 && ex_reg_write && ex_rd == src)
         return 2'd1;
      else if (src != '0 && mem_reg_write && mem_rd == src)
         return 2'd2;
      else
         return 2'd0;
   endfunction

   assign fwd_a_sel = fwd_sel(ex_rs);
   assign fwd_b_sel = fwd_sel(ex_rt);
   assign hazard    = ex_mem_read && match_ex_rd;
`else
   // Without forwarding any in-flight writer stalls; WB is covered by write-before-read.
   assign hazard = (ex_mem_read && match_ex_rd) ||
                   (ex_reg_write && match_ex_rd) ||
                   (mem_reg_write && match_mem_rd);
`endif

   always_comb begin
      // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
      le_pc       = 1'b0;
      le_npc      = 1'b0;
      le_if_id    = 1'b0;
      flush_if_id = 1'b1;
      nop_id_ex   = 1'b1;
      pc_sel      = PC_SEQ;
      halted      = 1'b0;
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      stall_cnt_d = stall_cnt_q;

      case (state_q)
         ST_BOOT: begin
            boot_cnt_d = boot_cnt_q + 8'd1;
            if (boot_cnt_q == BOOT_LAST)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ex_branch_taken) begin
               le_pc    = 1'b1;
               le_npc   = 1'b1;
               le_if_id = 1'b1;
               pc_sel   = PC_BRANCH;
            end else if (hazard) begin
               flush_if_id = 1'b0;
               if (stall_cnt_q != '1)
                  stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else if (id_jump) begin
               le_pc     = 1'b1;
               le_npc    = 1'b1;
               le_if_id  = 1'b1;
               nop_id_ex = 1'b0;
               pc_sel    = PC_JUMP;
            end else begin
               le_pc       = 1'b1;
               le_npc      = 1'b1;
               le_if_id    = 1'b1;
               flush_if_id = 1'b0;
               nop_id_ex   = 1'b0;
            end
            // The current cycle completes normally; the halt takes effect next cycle.
            if (halt_req)
               state_d = ST_HALT;
         end
         ST_HALT: begin
            flush_if_id = 1'b0;
            halted      = 1'b1;
            if (resume)
               state_d = ST_RUN;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_BOOT;
         boot_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle-level model of the sequencing rules
// checked every cycle, plus directed vectors with literal expectations.
module tb_pipeline_hazard_ctrl;

   localparam int BOOT    = 2;
   localparam int CNT_MAX = 65535;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_uses_rs, id_uses_rt, id_jump;
   logic       ex_reg_write, ex_mem_read, ex_branch_taken, mem_reg_write;
   logic       halt_req, resume;
   logic       le_pc, le_npc, le_if_id, flush_if_id, nop_id_ex, halted;
   logic [1:0] pc_sel;
   logic [15:0] stall_count;
`ifdef FWD_EN
   logic [4:0] ex_rs, ex_rt;
   logic [1:0] fwd_a_sel, fwd_b_sel;
`endif

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT), .REG_W(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .halt_req(halt_req), .resume(resume),
      .le_pc(le_pc), .le_npc(le_npc), .le_if_id(le_if_id), .flush_if_id(flush_if_id),
      .nop_id_ex(nop_id_ex), .pc_sel(pc_sel), .halted(halted),
`ifdef FWD_EN
      .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // ---------------- behavioural model ----------------
   int boot_left = BOOT;   // cycles of boot hold still to go
   bit m_halted  = 1'b0;
   int m_stalls  = 0;

   function automatic bit id_reads(input logic [4:0] r);
      return (r != 5'd0) && ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r));
   endfunction

   function automatic bit must_stall();
`ifdef FWD_EN
      return ex_mem_read && id_reads(ex_rd);
`else
      return (ex_mem_read && id_reads(ex_rd)) || (ex_reg_write && id_reads(ex_rd)) ||
             (mem_reg_write && id_reads(mem_rd));
`endif
   endfunction

   function automatic int fwd_model(input logic [4:0] src);
      if (src != 5'd0 && ex_reg_write && ex_rd == src) return 1;
      if (src != 5'd0 && mem_reg_write && mem_rd == src) return 2;
      return 0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         boot_left <= BOOT;
         m_halted  <= 1'b0;
         m_stalls  <= 0;
      end else if (boot_left > 0) begin
         boot_left <= boot_left - 1;
      end else if (m_halted) begin
         if (resume) m_halted <= 1'b0;
      end else begin
         if (halt_req) m_halted <= 1'b1;
         if (!ex_branch_taken && must_stall() && m_stalls < CNT_MAX) m_stalls <= m_stalls + 1;
      end
   end

   // Compare every cycle, away from the rising edge.
   always @(negedge clk) begin
      int e_le, e_flush, e_nop, e_sel, e_halt;
      e_sel  = -1;   // -1: pc_sel is don't-care when the PC is not loaded
      e_halt = 0;
      if (!reset || boot_left > 0) begin
         e_le = 0; e_flush = 1; e_nop = 1; e_sel = 0;
      end else if (m_halted) begin
         e_le = 0; e_flush = 0; e_nop = 1; e_halt = 1;
      end else if (ex_branch_taken) begin
         e_le = 1; e_flush = 1; e_nop = 1; e_sel = 1;
      end else if (must_stall()) begin
         e_le = 0; e_flush = 0; e_nop = 1;
      end else if (id_jump) begin
         e_le = 1; e_flush = 1; e_nop = 0; e_sel = 2;
      end else begin
         e_le = 1; e_flush = 0; e_nop = 0; e_sel = 0;
      end
      check("model_le_pc", 32'(le_pc), 32'(e_le));
      check("model_le_npc", 32'(le_npc), 32'(e_le));
      check("model_le_if_id", 32'(le_if_id), 32'(e_le));
      check("model_flush", 32'(flush_if_id), 32'(e_flush));
      check("model_nop", 32'(nop_id_ex), 32'(e_nop));
      check("model_halted", 32'(halted), 32'(e_halt));
      check("model_stall_count", 32'(stall_count), 32'(m_stalls));
      if (e_sel >= 0) check("model_pc_sel", 32'(pc_sel), 32'(e_sel));
`ifdef FWD_EN
      check("model_fwd_a", 32'(fwd_a_sel), 32'(fwd_model(ex_rs)));
      check("model_fwd_b", 32'(fwd_b_sel), 32'(fwd_model(ex_rt)));
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
      ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0; ex_branch_taken = 0;
      mem_rd = '0; mem_reg_write = 0; halt_req = 0; resume = 0;
`ifdef FWD_EN
      ex_rs = '0; ex_rt = '0;
`endif
   endtask

   task automatic load_use(input logic [4:0] rd);
      ex_mem_read = 1; ex_rd = rd; id_rs = 5'd5; id_uses_rs = 1;
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      repeat (3) next_cycle();

      // 1: boot hold of two cycles after release
      reset = 1'b1;
      sample(); check("boot_c0_le_pc", 32'(le_pc), 32'd0);
      check("boot_c0_flush", 32'(flush_if_id), 32'd1);
      next_cycle(); halt_req = 1;   // ignored during BOOT
      sample(); check("boot_c1_le_pc", 32'(le_pc), 32'd0);
      next_cycle(); halt_req = 0;
      sample(); check("run_c2_le_pc", 32'(le_pc), 32'd1);
      check("run_c2_pc_sel", 32'(pc_sel), 32'd0);
      check("run_c2_halted", 32'(halted), 32'd0);

      // 2: load-use stall, then the same pattern on r0
      next_cycle(); load_use(5'd5);
      sample(); check("lu_le_pc", 32'(le_pc), 32'd0);
      check("lu_nop", 32'(nop_id_ex), 32'd1);
      next_cycle(); load_use(5'd0);
      sample(); check("lu_r0_le_pc", 32'(le_pc), 32'd1);
      check("lu_stall_count", 32'(stall_count), 32'd1);

      // 3: taken branch beats jump and load-use hazard
      next_cycle(); load_use(5'd5); id_jump = 1; ex_branch_taken = 1;
      sample(); check("br_pc_sel", 32'(pc_sel), 32'd1);
      check("br_flush", 32'(flush_if_id), 32'd1);
      check("br_nop", 32'(nop_id_ex), 32'd1);
      check("br_le_pc", 32'(le_pc), 32'd1);
      next_cycle(); clear_inputs(); id_jump = 1;
      sample(); check("br_stall_count", 32'(stall_count), 32'd1);
      check("jmp_pc_sel", 32'(pc_sel), 32'd2);
      check("jmp_nop", 32'(nop_id_ex), 32'd0);

      // 4: RAW on the MEM writer
      next_cycle(); clear_inputs(); mem_reg_write = 1; mem_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1;
`ifdef FWD_EN
      sample(); check("mem_raw_le_pc", 32'(le_pc), 32'd1);
      next_cycle(); clear_inputs();
      ex_reg_write = 1; ex_rd = 5'd3; mem_reg_write = 1; mem_rd = 5'd3; ex_rs = 5'd3; ex_rt = 5'd3;
      sample(); check("fwd_a_ex_wins", 32'(fwd_a_sel), 32'd1);
      next_cycle(); ex_reg_write = 0; ex_rs = 5'd0;
      sample(); check("fwd_b_mem", 32'(fwd_b_sel), 32'd2);
      check("fwd_a_r0", 32'(fwd_a_sel), 32'd0);
`else
      sample(); check("mem_raw_le_pc", 32'(le_pc), 32'd0);
      next_cycle(); clear_inputs(); ex_reg_write = 1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1;
      sample(); check("ex_raw_le_pc", 32'(le_pc), 32'd0);
      check("ex_raw_stall_count", 32'(stall_count), 32'd2);
`endif

      // 5: halt / resume
      next_cycle(); clear_inputs(); halt_req = 1;
      sample(); check("halt_req_cycle_le_pc", 32'(le_pc), 32'd1);
      next_cycle(); halt_req = 1;   // repeated request while halted is ignored
      sample(); check("halted_flag", 32'(halted), 32'd1);
      check("halted_le_pc", 32'(le_pc), 32'd0);
      next_cycle(); halt_req = 0; resume = 1;
      sample(); check("resume_cycle_halted", 32'(halted), 32'd1);
      next_cycle(); resume = 0;
      sample(); check("resumed_le_pc", 32'(le_pc), 32'd1);
      check("resumed_halted", 32'(halted), 32'd0);
      next_cycle(); halt_req = 1; resume = 1;   // both in RUN: halt wins
      next_cycle(); halt_req = 0; resume = 0;
      sample(); check("halt_and_resume", 32'(halted), 32'd1);
      next_cycle(); resume = 1;
      next_cycle(); resume = 0;

      // 6: saturate the stall counter, then reset in the middle of a stall
      load_use(5'd5);
      repeat (CNT_MAX + 4) next_cycle();
      sample(); check("sat_stall_count", 32'(stall_count), 32'hFFFF);
      check("sat_le_pc", 32'(le_pc), 32'd0);
      @(posedge clk); #2 reset = 1'b0;
      #1;
      check("rst_stall_count", 32'(stall_count), 32'd0);
      check("rst_le_pc", 32'(le_pc), 32'd0);
      check("rst_flush", 32'(flush_if_id), 32'd1);
      check("rst_nop", 32'(nop_id_ex), 32'd1);
      check("rst_halted", 32'(halted), 32'd0);
      next_cycle();
      reset = 1'b1;
      repeat (BOOT) next_cycle();
      sample(); check("post_rst_stall_le_pc", 32'(le_pc), 32'd0);
      next_cycle();
      sample(); check("post_rst_stall_count", 32'(stall_count), 32'd1);
      next_cycle(); clear_inputs();
      repeat (3) next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
